// File: rtl/fifo_write_operation_if.sv
// Bus bundle for the 8-entry FIFO write-side controller: push/pop requests,
// status flags, pointers and the eight storage outputs feeding the read mux.
interface fifo_write_operation_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  wr_ack;
    logic                  wr_err;
    logic                  rd_ack;
    logic                  rd_err;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   data_count;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] to_reg0;
    logic [DATA_WIDTH-1:0] to_reg1;
    logic [DATA_WIDTH-1:0] to_reg2;
    logic [DATA_WIDTH-1:0] to_reg3;
    logic [DATA_WIDTH-1:0] to_reg4;
    logic [DATA_WIDTH-1:0] to_reg5;
    logic [DATA_WIDTH-1:0] to_reg6;
    logic [DATA_WIDTH-1:0] to_reg7;

    // Requester side: issues push/pop, observes everything else.
    modport master (
        output wr_en, rd_en, din,
        input  wr_ack, wr_err, rd_ack, rd_err, full, empty, data_count,
               wr_ptr, rd_addr, state,
               to_reg0, to_reg1, to_reg2, to_reg3,
               to_reg4, to_reg5, to_reg6, to_reg7
    );

    // FIFO side: consumes requests, drives status and storage.
    modport slave (
        input  wr_en, rd_en, din,
        output wr_ack, wr_err, rd_ack, rd_err, full, empty, data_count,
               wr_ptr, rd_addr, state,
               to_reg0, to_reg1, to_reg2, to_reg3,
               to_reg4, to_reg5, to_reg6, to_reg7
    );
endinterface

// File: rtl/fifo_write_operation.sv
// Write-side controller and storage for an 8 x DATA_WIDTH FIFO.
// Owns the storage registers, the tail (wr_ptr) and head (rd_addr) pointers,
// the occupancy count and a 6-state request FSM with registered ack/err flags.
// Optional macro FIFO_STORAGE_CLR_EN: when defined, reset also clears storage;
// otherwise storage has no reset and keeps its contents across reset.
module fifo_write_operation #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    fifo_write_operation_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {
        INIT   = 3'b000,
        NO_OP  = 3'b001,
        WRITE  = 3'b010,
        WR_ERR = 3'b011,
        READ   = 3'b100,
        RD_ERR = 3'b101
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_addr_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic                  do_push;
    logic                  do_pop;

    // Next state depends only on the requests and occupancy; push/pop strobes
    // act on the same edge the request is sampled, and reset suppresses them.
    always_comb begin
        state_next = NO_OP;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        if (bus.wr_en && !bus.rd_en) begin
            if (count_reg == COUNT_FULL) begin
                state_next = WR_ERR;
            end else begin
                state_next = WRITE;
                do_push    = reset_n;
            end
        end else if (bus.rd_en && !bus.wr_en) begin
            if (count_reg == '0) begin
                state_next = RD_ERR;
            end else begin
                state_next = READ;
                do_pop     = reset_n;
            end
        end
    end

    // State register, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= INIT;
            wr_ptr_reg  <= '0;
            rd_addr_reg <= '0;
            count_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
                count_reg  <= count_reg + (ADDR_WIDTH + 1)'(1);
            end else if (do_pop) begin
                rd_addr_reg <= rd_addr_reg + ADDR_WIDTH'(1);
                count_reg   <= count_reg - (ADDR_WIDTH + 1)'(1);
            end
        end
    end

    // One register per entry; only the slot addressed by the tail pointer
    // loads on an accepted push.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [DATA_WIDTH-1:0] entry_reg;

        // Entry load on push (cleared on reset only when the macro is set).
        always_ff @(posedge clk) begin
`ifdef FIFO_STORAGE_CLR_EN
            if (!reset_n) begin
                entry_reg <= '0;
            end else if (do_push && (wr_ptr_reg == ADDR_WIDTH'(gi))) begin
                entry_reg <= bus.din;
            end
`else
            if (do_push && (wr_ptr_reg == ADDR_WIDTH'(gi))) begin
                entry_reg <= bus.din;
            end
`endif
        end
    end

    // Flags are pure decodes of registered state and count.
    assign bus.state      = state_reg;
    assign bus.wr_ack     = (state_reg == WRITE);
    assign bus.wr_err     = (state_reg == WR_ERR);
    assign bus.rd_ack     = (state_reg == READ);
    assign bus.rd_err     = (state_reg == RD_ERR);
    assign bus.full       = (count_reg == COUNT_FULL);
    assign bus.empty      = (count_reg == '0);
    assign bus.data_count = count_reg;
    assign bus.wr_ptr     = wr_ptr_reg;
    assign bus.rd_addr    = rd_addr_reg;

    assign bus.to_reg0 = g_entry[0].entry_reg;
    assign bus.to_reg1 = g_entry[1].entry_reg;
    assign bus.to_reg2 = g_entry[2].entry_reg;
    assign bus.to_reg3 = g_entry[3].entry_reg;
    assign bus.to_reg4 = g_entry[4].entry_reg;
    assign bus.to_reg5 = g_entry[5].entry_reg;
    assign bus.to_reg6 = g_entry[6].entry_reg;
    assign bus.to_reg7 = g_entry[7].entry_reg;
endmodule

// File: tb/tb_fifo_write_operation.sv
// Self-checking bench for fifo_write_operation: a directed vector table, a
// wrap-plus-reset sequence, and a randomized phase against a queue model.
module tb_fifo_write_operation;
    localparam int DW = 32;
    localparam int AW = 3;
    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_NO_OP  = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_WR_ERR = 3'd3;
    localparam logic [2:0] S_READ   = 3'd4;
    localparam logic [2:0] S_RD_ERR = 3'd5;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fifo_write_operation_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_write_operation #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    // Reference model: the FIFO contents as a queue, pointers as modulo-8
    // counts of accepted pushes/pops, and the last request classification.
    logic [31:0] mq[$];
    int          m_wp;
    int          m_ra;
    logic [2:0]  m_state;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] din;
        logic [2:0]  st;
        int          cnt;
        int          wp;
        int          ra;
        bit          chk;
        int          idx;
        logic [31:0] val;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [31:0] reg_at(input int idx);
        case (idx)
            0:       return bus.to_reg0;
            1:       return bus.to_reg1;
            2:       return bus.to_reg2;
            3:       return bus.to_reg3;
            4:       return bus.to_reg4;
            5:       return bus.to_reg5;
            6:       return bus.to_reg6;
            default: return bus.to_reg7;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, update the model, compare every output.
    task automatic step(input bit rst, input bit wr, input bit rd, input logic [31:0] d);
        reset_n    = !rst;
        bus.wr_en  = wr;
        bus.rd_en  = rd;
        bus.din    = d;
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            m_wp    = 0;
            m_ra    = 0;
            m_state = S_INIT;
        end else if (wr && !rd) begin
            if (mq.size() < 8) begin
                mq.push_back(d);
                m_wp    = (m_wp + 1) % 8;
                m_state = S_WRITE;
            end else begin
                m_state = S_WR_ERR;
            end
        end else if (rd && !wr) begin
            if (mq.size() > 0) begin
                void'(mq.pop_front());
                m_ra    = (m_ra + 1) % 8;
                m_state = S_READ;
            end else begin
                m_state = S_RD_ERR;
            end
        end else begin
            m_state = S_NO_OP;
        end
        txn++;
        $display("txn %0d rst=%0b wr=%0b rd=%0b din=%08h state=%0d count=%0d wr_ptr=%0d rd_addr=%0d",
                 txn, rst, wr, rd, d, bus.state, bus.data_count, bus.wr_ptr, bus.rd_addr);
        check("m_state",   32'(bus.state),      32'(m_state));
        check("m_count",   32'(bus.data_count), 32'(mq.size()));
        check("m_full",    32'(bus.full),       32'(mq.size() == 8));
        check("m_empty",   32'(bus.empty),      32'(mq.size() == 0));
        check("m_wr_ptr",  32'(bus.wr_ptr),     32'(m_wp));
        check("m_rd_addr", 32'(bus.rd_addr),    32'(m_ra));
        check("m_flags",   {28'd0, bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err},
              {28'd0, m_state == S_WRITE, m_state == S_WR_ERR, m_state == S_READ, m_state == S_RD_ERR});
        if (mq.size() > 0) check("m_head", reg_at(m_ra), mq[0]);
    endtask

    task automatic add(input bit wr, input bit rd, input logic [31:0] din, input logic [2:0] st,
                       input int cnt, input int wp, input int ra,
                       input bit chk, input int idx, input logic [31:0] val);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.st = st;
        v.cnt = cnt; v.wp = wp; v.ra = ra;
        v.chk = chk; v.idx = idx; v.val = val;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] seq_vals[11];
        reset_n    = 1'b0;
        bus.wr_en  = 1'b0;
        bus.rd_en  = 1'b0;
        bus.din    = '0;

        // Directed table: idle, fill, overflow, drain, underflow, simultaneous.
        for (int i = 0; i < 3; i++) add(0, 0, 32'h0, S_NO_OP, 0, 0, 0, 0, 0, 32'h0);
        for (int k = 0; k < 8; k++)
            add(1, 0, 32'h11111111 * (k + 1), S_WRITE, k + 1, (k + 1) % 8, 0,
                1, k, 32'h11111111 * (k + 1));
        add(1, 0, 32'hDEADBEEF, S_WR_ERR, 8, 0, 0, 1, 0, 32'h11111111);
        for (int k = 0; k < 8; k++)
            add(0, 1, 32'h0, S_READ, 7 - k, 0, (k + 1) % 8,
                k < 7, (k + 1) % 8, 32'h11111111 * (k + 2));
        add(0, 1, 32'h0, S_RD_ERR, 0, 0, 0, 0, 0, 32'h0);
        add(1, 0, 32'hA5A5A5A5, S_WRITE, 1, 1, 0, 1, 0, 32'hA5A5A5A5);
        add(1, 0, 32'h5A5A5A5A, S_WRITE, 2, 2, 0, 1, 1, 32'h5A5A5A5A);
        add(1, 1, 32'hFFFFFFFF, S_NO_OP, 2, 2, 0, 1, 2, 32'h33333333);
        add(0, 0, 32'h0, S_NO_OP, 2, 2, 0, 1, 0, 32'hA5A5A5A5);

        // Reset state.
        step(1, 0, 0, 32'h0);
        check("rst_state", 32'(bus.state), 32'(S_INIT));
        check("rst_status", {26'd0, bus.empty, bus.full, bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err},
              32'b100000);

        foreach (vecs[i]) begin
            step(0, vecs[i].wr, vecs[i].rd, vecs[i].din);
            check($sformatf("vec%0d_state", i),   32'(bus.state),      32'(vecs[i].st));
            check($sformatf("vec%0d_count", i),   32'(bus.data_count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_wr_ptr", i),  32'(bus.wr_ptr),     32'(vecs[i].wp));
            check($sformatf("vec%0d_rd_addr", i), 32'(bus.rd_addr),    32'(vecs[i].ra));
            check($sformatf("vec%0d_full", i),    32'(bus.full),       32'(vecs[i].cnt == 8));
            check($sformatf("vec%0d_empty", i),   32'(bus.empty),      32'(vecs[i].cnt == 0));
            if (vecs[i].chk)
                check($sformatf("vec%0d_to_reg%0d", i, vecs[i].idx), reg_at(vecs[i].idx), vecs[i].val);
        end

        // Wrap sequence: push 5, pop 5, push 6, then reset with a push pending.
        step(1, 0, 0, 32'h0);
        for (int k = 0; k < 11; k++) seq_vals[k] = $urandom;
        for (int k = 0; k < 5; k++) step(0, 1, 0, seq_vals[k]);
        for (int k = 0; k < 5; k++) step(0, 0, 1, 32'h0);
        for (int k = 5; k < 11; k++) step(0, 1, 0, seq_vals[k]);
        check("wrap_wr_ptr",  32'(bus.wr_ptr),     32'd3);
        check("wrap_rd_addr", 32'(bus.rd_addr),    32'd5);
        check("wrap_count",   32'(bus.data_count), 32'd6);
        check("wrap_head",    reg_at(5),           seq_vals[5]);
        step(1, 1, 0, 32'hCAFEF00D);
        check("midrst_state", 32'(bus.state), 32'(S_INIT));
        check("midrst_ptrs",  {26'd0, bus.wr_ptr, bus.rd_addr}, 32'd0);
        check("midrst_count", 32'(bus.data_count), 32'd0);
`ifdef FIFO_STORAGE_CLR_EN
        for (int k = 0; k < 8; k++) check($sformatf("midrst_to_reg%0d", k), reg_at(k), 32'h0);
`else
        check("midrst_keep_to_reg2", reg_at(2), seq_vals[10]);
        check("midrst_keep_to_reg5", reg_at(5), seq_vals[5]);
`endif

        // Randomized phase: fill-biased then drain-biased, with rare resets.
        for (int n = 0; n < 400; n++) begin
            int wr_pct;
            int rd_pct;
            wr_pct = (n < 200) ? 65 : 35;
            rd_pct = 100 - wr_pct;
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < wr_pct,
                 $urandom_range(0, 99) < rd_pct,
                 $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
